// File: rtl/i2c_s_regs.sv
// I2C/SCCB slave emulating a 256x8 camera register file, with write strobes and a local read port.
// Optional macro I2C_S_GLITCH_FILTER_EN adds a 3-sample glitch filter on SCL/SDA after the synchronizer.
module i2c_s_regs #(
    parameter logic [6:0] DEV_ADR = 7'h21,
    parameter logic [7:0] PTR_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       busy,
    output logic       reg_wr,
    output logic [7:0] reg_wr_adr,
    output logic [7:0] reg_wr_data,
    input  logic [7:0] loc_adr,
    output logic [7:0] loc_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK, S_WPTR, S_WDATA, S_RDATA, S_MACK, S_IGNORE
    } state_t;

    // Handshake: none; the bus side follows I2C timing, reg_wr is a one-cycle strobe with no back-pressure.

    logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic scl_h_q, sda_h_q;
    logic scl_cur, sda_cur;

`ifdef I2C_S_GLITCH_FILTER_EN
    logic scl_p1_q, scl_p2_q, sda_p1_q, sda_p2_q, scl_flt_q, sda_flt_q;

    // Filtered value follows the synchronized input only once it has held for three samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p1_q  <= 1'b1;
            scl_p2_q  <= 1'b1;
            sda_p1_q  <= 1'b1;
            sda_p2_q  <= 1'b1;
            scl_flt_q <= 1'b1;
            sda_flt_q <= 1'b1;
        end else begin
            scl_p1_q <= scl_s2_q;
            scl_p2_q <= scl_p1_q;
            sda_p1_q <= sda_s2_q;
            sda_p2_q <= sda_p1_q;
            if (scl_s2_q == scl_p1_q && scl_p1_q == scl_p2_q) scl_flt_q <= scl_s2_q;
            if (sda_s2_q == sda_p1_q && sda_p1_q == sda_p2_q) sda_flt_q <= sda_s2_q;
        end
    end

    assign scl_cur = scl_flt_q;
    assign sda_cur = sda_flt_q;
`else
    assign scl_cur = scl_s2_q;
    assign sda_cur = sda_s2_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
            scl_h_q  <= scl_cur;
            sda_h_q  <= sda_cur;
        end
    end

    logic scl_rise, scl_fall, start_ev, stop_ev;
    assign scl_rise = scl_cur & ~scl_h_q;
    assign scl_fall = ~scl_cur & scl_h_q;
    // SCL must be high in both samples so a simultaneous SCL/SDA drop is not taken as START.
    assign start_ev = scl_cur & scl_h_q & sda_h_q & ~sda_cur;
    assign stop_ev  = scl_cur & scl_h_q & ~sda_h_q & sda_cur;

    state_t      state_q, state_d, ack_nxt_q, ack_nxt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        phase_q, phase_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        sda_o_q, sda_o_d;
    logic        busy_q, busy_d;
    logic        wr_q, wr_d;
    logic [7:0]  wr_adr_q, wr_adr_d, wr_data_q, wr_data_d;
    logic [7:0]  loc_rd_q;
    logic [7:0]  regs_q [256];
    logic        mem_we;
    logic [7:0]  byte_in, rd_byte;

    assign byte_in = {shift_q[6:0], sda_cur};
    assign rd_byte = regs_q[ptr_q];

    always_comb begin
        state_d   = state_q;
        ack_nxt_d = ack_nxt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        phase_d   = phase_q;
        ptr_d     = ptr_q;
        sda_o_d   = sda_o_q;
        busy_d    = busy_q;
        wr_d      = 1'b0;
        wr_adr_d  = wr_adr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;
        if (stop_ev) begin
            state_d = S_IDLE;
            sda_o_d = 1'b1;
            busy_d  = 1'b0;
        end else if (start_ev) begin
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ADDR, S_WPTR, S_WDATA: begin
                    if (scl_fall) sda_o_d = 1'b1;
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            phase_d   = 1'b0;
                            state_d   = S_ACK;
                            ack_nxt_d = S_WDATA;
                            if (state_q == S_ADDR) begin
                                if (byte_in[7:1] == DEV_ADR) begin
                                    busy_d    = 1'b1;
                                    ack_nxt_d = byte_in[0] ? S_RDATA : S_WPTR;
                                end else begin
                                    state_d = S_IGNORE;
                                end
                            end else if (state_q == S_WPTR) begin
                                ptr_d = byte_in;
                            end else begin
                                mem_we    = 1'b1;
                                wr_d      = 1'b1;
                                wr_adr_d  = ptr_q;
                                wr_data_d = byte_in;
                                ptr_d     = ptr_q + 8'd1;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_o_d = 1'b0;
                            phase_d = 1'b1;
                        end else begin
                            sda_o_d   = 1'b1;
                            state_d   = ack_nxt_q;
                            bit_cnt_d = 4'd0;
                            if (ack_nxt_q == S_RDATA) begin
                                shift_d = {rd_byte[6:0], 1'b1};
                                sda_o_d = rd_byte[7];
                                ptr_d   = ptr_q + 8'd1;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_o_d = 1'b1;
                            phase_d = 1'b0;
                            state_d = S_MACK;
                        end else begin
                            sda_o_d = shift_q[7];
                            shift_d = {shift_q[6:0], 1'b1};
                        end
                    end
                end
                S_MACK: begin
                    if (scl_rise) begin
                        if (sda_cur) state_d = S_IGNORE;
                        else         phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        state_d   = S_RDATA;
                        bit_cnt_d = 4'd0;
                        shift_d   = {rd_byte[6:0], 1'b1};
                        sda_o_d   = rd_byte[7];
                        ptr_d     = ptr_q + 8'd1;
                    end
                end
                S_IGNORE: begin
                    if (scl_fall) sda_o_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ack_nxt_q <= S_WPTR;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            phase_q   <= 1'b0;
            ptr_q     <= PTR_RST;
            sda_o_q   <= 1'b1;
            busy_q    <= 1'b0;
            wr_q      <= 1'b0;
            wr_adr_q  <= 8'h00;
            wr_data_q <= 8'h00;
            loc_rd_q  <= 8'h00;
            for (int i = 0; i < 256; i++) regs_q[i] <= 8'h00;
        end else begin
            state_q   <= state_d;
            ack_nxt_q <= ack_nxt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            phase_q   <= phase_d;
            ptr_q     <= ptr_d;
            sda_o_q   <= sda_o_d;
            busy_q    <= busy_d;
            wr_q      <= wr_d;
            wr_adr_q  <= wr_adr_d;
            wr_data_q <= wr_data_d;
            // Local read samples the array before this cycle's write lands.
            loc_rd_q  <= regs_q[loc_adr];
            if (mem_we) regs_q[ptr_q] <= byte_in;
        end
    end

    assign sda_o       = sda_o_q;
    assign busy        = busy_q;
    assign reg_wr      = wr_q;
    assign reg_wr_adr  = wr_adr_q;
    assign reg_wr_data = wr_data_q;
    assign loc_rd_data = loc_rd_q;

endmodule
